// File: rtl/julia_param_ctrl.sv
// julia_param_ctrl
// Parameter controller that sits directly upstream of the julia_set_stripe
// instances. It takes user view and constant commands, updates the fractal
// parameters, and launches a redraw with a one-cycle valid/update strobe.
// It then tracks render completion through the stripes' combined pause
// signal and reports how long the render took in clock cycles.
//
// Ports
//   clock         : system clock, all logic on the rising edge
//   reset         : asynchronous, active-low reset
//   cmd           : command code, captured when a command is accepted
//   cmd_valid     : command present (level)
//   step_sel      : constant-adjust step select (16/64/256/1024 LSB)
//   pause_all     : AND of all stripes' pause_signal (1 = all stripes done)
//   cmd_ready     : controller can accept a command (combinational)
//   c_real_wire   : signed 3.15 Julia constant, real part
//   c_comp_wire   : signed 3.15 Julia constant, imaginary part
//   x_wire        : signed 3.15 view centre x
//   y_wire        : signed 3.15 view centre y
//   scale_wire    : signed 3.15 view scale
//   valid         : one-cycle parameter strobe
//   update        : one-cycle redraw strobe, coincident with valid
//   render_cycles : clock count of the last completed render
//   busy          : a render is in progress
//   ack_error     : sticky, a stripe failed to acknowledge an update

module julia_param_ctrl #(
  parameter int          ACK_TIMEOUT = 15,
  parameter logic [17:0] SCALE_MIN   = 18'd64,
  parameter logic [17:0] SCALE_MAX   = 18'h1FFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         cmd,
  input  logic               cmd_valid,
  input  logic [1:0]         step_sel,
  input  logic               pause_all,
  output logic               cmd_ready,
  output logic signed [17:0] c_real_wire,
  output logic signed [17:0] c_comp_wire,
  output logic signed [17:0] x_wire,
  output logic signed [17:0] y_wire,
  output logic signed [17:0] scale_wire,
  output logic               valid,
  output logic               update,
  output logic [31:0]        render_cycles,
  output logic               busy,
  output logic               ack_error
);

  localparam int ACK_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  localparam logic signed [17:0] C_REAL_DEF = -18'sd26214;
  localparam logic signed [17:0] C_COMP_DEF = 18'sd5112;
  localparam logic signed [17:0] SCALE_DEF  = 18'sd65536;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    UPDATE,
    WAIT_ACK,
    RENDER
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cmd_q;
  logic [1:0]       step_q;
  logic [31:0]      render_cnt;
  logic [31:0]      cnt_inc;
  logic [ACK_W-1:0] ack_cnt;
  logic             accept;
  logic             ack_expire;

  logic signed [17:0] c_real_nxt, c_comp_nxt, x_nxt, y_nxt, scale_nxt;
  logic signed [17:0] scale_tmp;
  logic signed [17:0] step_val;

  // Overflow of a 19-bit sum shows up as the top two bits disagreeing; the
  // top bit then tells us which rail to clamp to.
  function automatic logic signed [17:0] sat_add(input logic signed [17:0] a,
                                                 input logic signed [17:0] b);
    logic signed [18:0] sum;
    sum = {a[17], a} + {b[17], b};
    if (sum[18] != sum[17])
      sat_add = sum[18] ? 18'sh20000 : 18'sh1FFFF;
    else
      sat_add = sum[17:0];
  endfunction

  function automatic logic signed [17:0] sat_sub(input logic signed [17:0] a,
                                                 input logic signed [17:0] b);
    logic signed [18:0] diff;
    diff = {a[17], a} - {b[17], b};
    if (diff[18] != diff[17])
      sat_sub = diff[18] ? 18'sh20000 : 18'sh1FFFF;
    else
      sat_sub = diff[17:0];
  endfunction

  assign cmd_ready  = (state == IDLE) && pause_all;
  assign accept     = cmd_ready && cmd_valid;
  assign ack_expire = (state == WAIT_ACK) && pause_all && (ack_cnt == ACK_LAST);
  assign cnt_inc    = (render_cnt == 32'hFFFF_FFFF) ? render_cnt : render_cnt + 32'd1;

  // Next-state logic. Codes 12-15 are accepted but fall straight back to
  // IDLE without a redraw.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = APPLY;
      APPLY:    state_nxt = (cmd_q >= 4'd12) ? IDLE : UPDATE;
      UPDATE:   state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (!pause_all)
          state_nxt = RENDER;
        else if (ack_expire)
          state_nxt = IDLE;
      end
      RENDER:   if (pause_all) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // New parameter values, only different from the held ones in APPLY.
  always_comb begin
    c_real_nxt = c_real_wire;
    c_comp_nxt = c_comp_wire;
    x_nxt      = x_wire;
    y_nxt      = y_wire;
    scale_nxt  = scale_wire;
    scale_tmp  = scale_wire;
    case (step_q)
      2'd0:    step_val = 18'sd16;
      2'd1:    step_val = 18'sd64;
      2'd2:    step_val = 18'sd256;
      default: step_val = 18'sd1024;
    endcase
    if (state == APPLY) begin
      case (cmd_q)
        4'd1:  x_nxt = sat_sub(x_wire, scale_wire >>> 3);
        4'd2:  x_nxt = sat_add(x_wire, scale_wire >>> 3);
        4'd3:  y_nxt = sat_sub(y_wire, scale_wire >>> 3);
        4'd4:  y_nxt = sat_add(y_wire, scale_wire >>> 3);
        4'd5: begin
          scale_tmp = sat_sub(scale_wire, scale_wire >>> 2);
          scale_nxt = (scale_tmp < $signed(SCALE_MIN)) ? $signed(SCALE_MIN) : scale_tmp;
        end
        4'd6: begin
          scale_tmp = sat_add(scale_wire, scale_wire >>> 2);
          scale_nxt = (scale_tmp > $signed(SCALE_MAX)) ? $signed(SCALE_MAX) : scale_tmp;
        end
        4'd7:  c_real_nxt = sat_add(c_real_wire, step_val);
        4'd8:  c_real_nxt = sat_sub(c_real_wire, step_val);
        4'd9:  c_comp_nxt = sat_add(c_comp_wire, step_val);
        4'd10: c_comp_nxt = sat_sub(c_comp_wire, step_val);
        4'd11: begin
          c_real_nxt = C_REAL_DEF;
          c_comp_nxt = C_COMP_DEF;
          x_nxt      = '0;
          y_nxt      = '0;
          scale_nxt  = SCALE_DEF;
        end
        default: ;
      endcase
    end
  end

  // Parameter registers. These feed the stripes directly, so they only
  // move in APPLY and are stable by the time the update strobe fires.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      c_real_wire <= C_REAL_DEF;
      c_comp_wire <= C_COMP_DEF;
      x_wire      <= '0;
      y_wire      <= '0;
      scale_wire  <= SCALE_DEF;
    end else begin
      c_real_wire <= c_real_nxt;
      c_comp_wire <= c_comp_nxt;
      x_wire      <= x_nxt;
      y_wire      <= y_nxt;
      scale_wire  <= scale_nxt;
    end
  end

  // Control state, strobes and counters. Reset lands in RENDER because the
  // stripes start their own first render out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= RENDER;
      cmd_q         <= '0;
      step_q        <= '0;
      valid         <= 1'b0;
      update        <= 1'b0;
      busy          <= 1'b1;
      render_cnt    <= '0;
      render_cycles <= '0;
      ack_cnt       <= '0;
      ack_error     <= 1'b0;
    end else begin
      state  <= state_nxt;
      valid  <= (state_nxt == UPDATE);
      update <= (state_nxt == UPDATE);
      busy   <= (state_nxt != IDLE);
      if (accept) begin
        cmd_q  <= cmd;
        step_q <= step_sel;
      end
      case (state)
        UPDATE: begin
          render_cnt <= '0;
          ack_cnt    <= '0;
        end
        WAIT_ACK: begin
          if (pause_all) begin
            if (ack_expire)
              ack_error <= 1'b1;
            else
              ack_cnt <= ack_cnt + 1'b1;
          end
        end
        RENDER: begin
          render_cnt <= cnt_inc;
          if (pause_all)
            render_cycles <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_param_ctrl.sv
// tb_julia_param_ctrl
// Self-checking bench for julia_param_ctrl. Directed commands are issued by
// the stimulus process, which also pushes the expected parameter set for
// every redraw into a queue. A monitor pops and compares on each valid pulse.
// Ports: none (top-level bench).

module tb_julia_param_ctrl;

  typedef struct packed {
    logic signed [17:0] cr;
    logic signed [17:0] cc;
    logic signed [17:0] x;
    logic signed [17:0] y;
    logic signed [17:0] s;
  } params_t;

  logic               clock;
  logic               reset;
  logic [3:0]         cmd;
  logic               cmd_valid;
  logic [1:0]         step_sel;
  logic               pause_all;
  logic               cmd_ready;
  logic signed [17:0] c_real_wire;
  logic signed [17:0] c_comp_wire;
  logic signed [17:0] x_wire;
  logic signed [17:0] y_wire;
  logic signed [17:0] scale_wire;
  logic               valid;
  logic               update;
  logic [31:0]        render_cycles;
  logic               busy;
  logic               ack_error;

  int checks   = 0;
  int failures = 0;

  params_t exp_q[$];

  int m_cr, m_cc, m_x, m_y, m_s;

  julia_param_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .cmd           (cmd),
    .cmd_valid     (cmd_valid),
    .step_sel      (step_sel),
    .pause_all     (pause_all),
    .cmd_ready     (cmd_ready),
    .c_real_wire   (c_real_wire),
    .c_comp_wire   (c_comp_wire),
    .x_wire        (x_wire),
    .y_wire        (y_wire),
    .scale_wire    (scale_wire),
    .valid         (valid),
    .update        (update),
    .render_cycles (render_cycles),
    .busy          (busy),
    .ack_error     (ack_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int sat18(input int v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  task automatic model_reset();
    m_cr = -26214;
    m_cc = 5112;
    m_x  = 0;
    m_y  = 0;
    m_s  = 65536;
  endtask

  task automatic model_apply(input logic [3:0] code, input logic [1:0] sel);
    int step;
    step = 16 << (2 * int'(sel));
    case (code)
      4'd1:  m_x  = sat18(m_x - (m_s >>> 3));
      4'd2:  m_x  = sat18(m_x + (m_s >>> 3));
      4'd3:  m_y  = sat18(m_y - (m_s >>> 3));
      4'd4:  m_y  = sat18(m_y + (m_s >>> 3));
      4'd5: begin
        m_s = sat18(m_s - (m_s >>> 2));
        if (m_s < 64) m_s = 64;
      end
      4'd6:  m_s  = sat18(m_s + (m_s >>> 2));
      4'd7:  m_cr = sat18(m_cr + step);
      4'd8:  m_cr = sat18(m_cr - step);
      4'd9:  m_cc = sat18(m_cc + step);
      4'd10: m_cc = sat18(m_cc - step);
      4'd11: model_reset();
      default: ;
    endcase
  endtask

  function automatic params_t model_pack();
    params_t p;
    p.cr = 18'(m_cr);
    p.cc = 18'(m_cc);
    p.x  = 18'(m_x);
    p.y  = 18'(m_y);
    p.s  = 18'(m_s);
    return p;
  endfunction

  task automatic check_params(input string tag);
    check_output({tag, "_c_real"}, c_real_wire, m_cr);
    check_output({tag, "_c_comp"}, c_comp_wire, m_cc);
    check_output({tag, "_x"}, x_wire, m_x);
    check_output({tag, "_y"}, y_wire, m_y);
    check_output({tag, "_scale"}, scale_wire, m_s);
  endtask

  // Issue one command and walk it through a full render of len cycles.
  // With hold set, cmd_valid stays high until the render ends, so any
  // second acceptance would show up as an extra valid pulse.
  task automatic apply_stimulus(input logic [3:0] code, input logic [1:0] sel,
                                input int len, input bit hold);
    check_output("cmd_ready_before_accept", cmd_ready, 1);
    cmd       = code;
    step_sel  = sel;
    cmd_valid = 1'b1;
    if (code <= 4'd11) begin
      model_apply(code, sel);
      exp_q.push_back(model_pack());
    end
    tick();
    if (!hold) cmd_valid = 1'b0;
    check_output("apply_busy", busy, 1);
    check_output("apply_cmd_ready", cmd_ready, 0);
    check_output("apply_no_valid", valid, 0);
    if (code >= 4'd12) begin
      tick();
      check_output("noop_busy", busy, 0);
      check_output("noop_cmd_ready", cmd_ready, 1);
    end else begin
      tick();
      check_output("valid_at_accept_plus2", valid, 1);
      check_output("update_at_accept_plus2", update, 1);
      tick();
      check_output("valid_single_cycle", valid, 0);
      pause_all = 1'b0;
      tick();
      for (int i = 1; i < len; i++) tick();
      pause_all = 1'b1;
      cmd_valid = 1'b0;
      tick();
      check_output("render_cycles", render_cycles, len);
      check_output("busy_after_render", busy, 0);
    end
  endtask

  // Scoreboard monitor: every strobe must carry both valid and update and
  // match the oldest outstanding expected parameter set.
  always @(negedge clock) begin
    params_t e;
    if (reset && (valid || update)) begin
      check_output("strobe_valid", valid, 1);
      check_output("strobe_update", update, 1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_strobe: got a valid pulse, expected none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check_output("sb_c_real", c_real_wire, $signed(e.cr));
        check_output("sb_c_comp", c_comp_wire, $signed(e.cc));
        check_output("sb_x", x_wire, $signed(e.x));
        check_output("sb_y", y_wire, $signed(e.y));
        check_output("sb_scale", scale_wire, $signed(e.s));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    cmd       = 4'd0;
    cmd_valid = 1'b0;
    step_sel  = 2'd0;
    pause_all = 1'b0;
    model_reset();

    // Reset values
    #12;
    check_params("reset");
    check_output("reset_valid", valid, 0);
    check_output("reset_update", update, 0);
    check_output("reset_cmd_ready", cmd_ready, 0);
    check_output("reset_busy", busy, 1);
    check_output("reset_render_cycles", render_cycles, 0);
    check_output("reset_ack_error", ack_error, 0);
    reset = 1'b1;

    // First render after reset: 100 cycles with pause_all low
    repeat (100) tick();
    check_output("first_render_busy", busy, 1);
    check_output("first_render_cmd_ready", cmd_ready, 0);
    pause_all = 1'b1;
    tick();
    checks++;
    if (render_cycles < 99 || render_cycles > 101) begin
      failures++;
      $display("[TB] FAIL first_render_cycles: got %0d, expected 100 +/-1", render_cycles);
    end
    check_output("first_render_idle_busy", busy, 0);
    check_output("first_render_idle_ready", cmd_ready, 1);
    check_params("post_reset");

    // Zoom in once, 50-cycle render
    apply_stimulus(4'd5, 2'd0, 50, 1'b0);
    check_output("zoom_in_scale", scale_wire, 49152);

    // Pan and constant adjustments
    apply_stimulus(4'd1, 2'd0, 2, 1'b0);
    check_output("pan_left_x", x_wire, -6144);
    apply_stimulus(4'd4, 2'd0, 3, 1'b0);
    check_output("pan_down_y", y_wire, 6144);
    apply_stimulus(4'd9, 2'd0, 1, 1'b0);
    check_output("c_comp_plus16", c_comp_wire, 5128);
    apply_stimulus(4'd10, 2'd1, 1, 1'b0);
    check_output("c_comp_minus64", c_comp_wire, 5064);
    apply_stimulus(4'd8, 2'd2, 2, 1'b0);
    check_output("c_real_minus256", c_real_wire, -26470);
    apply_stimulus(4'd2, 2'd0, 4, 1'b1);
    check_output("held_cmd_x", x_wire, 0);
    apply_stimulus(4'd11, 2'd0, 1, 1'b0);
    check_params("restore_defaults");

    // Scale floor and ceiling
    for (int i = 0; i < 40; i++) apply_stimulus(4'd5, 2'd0, 1, 1'b0);
    check_output("scale_floor", scale_wire, 64);
    for (int i = 0; i < 45; i++) apply_stimulus(4'd6, 2'd0, 1, 1'b0);
    check_output("scale_ceiling", scale_wire, 131071);

    // c_real ramp with the largest step up to saturation
    apply_stimulus(4'd11, 2'd0, 1, 1'b0);
    apply_stimulus(4'd7, 2'd3, 1, 1'b0);
    check_output("c_real_step1", c_real_wire, -25190);
    apply_stimulus(4'd7, 2'd3, 1, 1'b0);
    check_output("c_real_step2", c_real_wire, -24166);
    for (int i = 0; i < 152; i++) apply_stimulus(4'd7, 2'd3, 1, 1'b0);
    check_output("c_real_saturated", c_real_wire, 131071);
    apply_stimulus(4'd7, 2'd3, 1, 1'b0);
    check_output("c_real_no_wrap", c_real_wire, 131071);

    // Stripes never acknowledge: pause_all stays high after the strobe
    check_output("ack_error_before", ack_error, 0);
    cmd       = 4'd0;
    cmd_valid = 1'b1;
    model_apply(4'd0, 2'd0);
    exp_q.push_back(model_pack());
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    repeat (14) tick();
    check_output("ack_wait_busy", busy, 1);
    check_output("ack_wait_no_error", ack_error, 0);
    tick();
    check_output("ack_timeout_error", ack_error, 1);
    check_output("ack_timeout_idle", busy, 0);
    check_output("ack_timeout_ready", cmd_ready, 1);
    apply_stimulus(4'd0, 2'd0, 3, 1'b0);
    check_output("ack_error_sticky", ack_error, 1);

    // Codes 12-15 do nothing
    apply_stimulus(4'd13, 2'd0, 1, 1'b0);
    check_params("noop_cmd13");

    // Spurious pause_all drop while idle
    pause_all = 1'b0;
    #1;
    check_output("spurious_cmd_ready", cmd_ready, 0);
    cmd       = 4'd2;
    cmd_valid = 1'b1;
    repeat (3) tick();
    check_output("spurious_busy", busy, 0);
    cmd_valid = 1'b0;
    pause_all = 1'b1;
    #1;
    check_output("spurious_recovered", cmd_ready, 1);
    check_params("spurious_params");

    // Reset asserted in the middle of a render
    apply_stimulus(4'd6, 2'd0, 1, 1'b0);
    cmd       = 4'd3;
    cmd_valid = 1'b1;
    model_apply(4'd3, 2'd0);
    exp_q.push_back(model_pack());
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pause_all = 1'b0;
    tick();
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_params("async_reset");
    check_output("async_reset_ack_error", ack_error, 0);
    check_output("async_reset_busy", busy, 1);
    check_output("async_reset_render_cycles", render_cycles, 0);
    check_output("async_reset_cmd_ready", cmd_ready, 0);
    #2;
    reset     = 1'b1;
    pause_all = 1'b1;
    tick();
    check_output("post_reset_render_cycles", render_cycles, 1);
    check_output("post_reset_busy", busy, 0);
    check_output("post_reset_ready", cmd_ready, 1);

    repeat (2) tick();
    check_output("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/julia_param_ctrl.md
# julia_param_ctrl

Parameter controller directly upstream of the `julia_set_stripe` instances. It accepts user view and constant commands, updates the fractal parameters, and launches a redraw. Launching means pulsing `valid`/`update` into every stripe, then tracking render completion through the stripes' combined `pause_signal`. It also measures render time in clock cycles for display.

## Interface
Parameters:
- `ACK_TIMEOUT`, 15: cycles allowed for `pause_all` to fall after an update pulse.
- `SCALE_MIN`, 18'd64: lower clamp on `scale_wire` (3.15 LSBs).
- `SCALE_MAX`, 18'h1FFFF: upper clamp on `scale_wire`.

Ports:
- `clock`, in, 1: single system clock; all logic is on the rising edge.
- `reset`, in, 1: **asynchronous, active-low** reset.
- `cmd`, in, 4: command code, sampled on the accept cycle.
- `cmd_valid`, in, 1: command present (level).
- `step_sel`, in, 2: constant-adjust step select.
- `pause_all`, in, 1: AND of all stripes' `pause_signal`; 1 means every stripe has finished.
- `cmd_ready`, out, 1: controller can accept a command.
- `c_real_wire`, `c_comp_wire`, `x_wire`, `y_wire`, `scale_wire`, out, 18 each: signed 3.15 parameters driven to all stripes.
- `valid`, out, 1: parameter strobe, one cycle.
- `update`, out, 1: redraw strobe, one cycle, coincident with `valid`.
- `render_cycles`, out, 32: clock count of the last completed render.
- `busy`, out, 1: a render is in progress.
- `ack_error`, out, 1: sticky flag; set when a stripe fails to acknowledge an update.

## Operation
All arithmetic is 18-bit signed 3.15. Representable range is −4.0 to +4.0−2^-15. Every add or subtract saturates to 18'h1FFFF / 18'h20000 and never wraps.

Reset (async assert, `reset`=0) drives these values:
- c_real = −26214 (−0.8), c_comp = 5112 (0.156), x = 0, y = 0, scale = 65536 (2.0).
- `valid` = `update` = `cmd_ready` = 0, `render_cycles` = 0, `ack_error` = 0.
- `busy` = 1, state = RENDER. The stripes self-initialise on reset, so the controller waits for their first render to finish.

States:
- **IDLE**: `cmd_ready` = `pause_all`. A command is accepted when `cmd_valid & cmd_ready`; the next state is APPLY.
- **APPLY**: one cycle. Registers the new parameters by command code:
  - 0: redraw only, no parameter change.
  - 1 / 2: x −= / += scale>>>3.
  - 3 / 4: y −= / += scale>>>3.
  - 5: scale −= scale>>>2, clamped to ≥ SCALE_MIN.
  - 6: scale += scale>>>2, clamped to ≤ SCALE_MAX.
  - 7 / 8: c_real += / −= step.
  - 9 / 10: c_comp += / −= step.
  - 11: restore the reset defaults.
  - 12–15: no change and no redraw; next state is IDLE.
  - For codes 0–11, next state is UPDATE.
- **step**: 1 <<< (2·`step_sel` + 4), giving 16, 64, 256 or 1024 LSB.
- **UPDATE**: `valid` = `update` = 1 for exactly this cycle. Parameters are already stable and stay held until the next APPLY. Clears the render counter. Next state is WAIT_ACK.
- **WAIT_ACK**:
  - If `pause_all` = 0, go to RENDER.
  - If ACK_TIMEOUT cycles elapse with `pause_all` still 1, set `ack_error` and go to IDLE.
- **RENDER**: `busy` = 1 and the counter increments every cycle, saturating at 2^32−1. When `pause_all` = 1, load `render_cycles` from the counter and go to IDLE.
- `busy` = 1 in APPLY, UPDATE, WAIT_ACK and RENDER. `busy` = 0 in IDLE.
- `ack_error` clears only on reset.

## Timing
- Command accept in cycle N produces:
  - N+1: APPLY.
  - N+2: `valid`/`update` high with the new parameters already visible on the outputs.
  - N+3: WAIT_ACK.
- `cmd_ready` is combinational from state and `pause_all`. It is low in every non-IDLE state.
- A command held across several cycles is accepted once. The second acceptance can occur no earlier than the first return to IDLE.
- If `pause_all` rises in the cycle the controller enters RENDER, it completes in one further cycle with `render_cycles` = 1.
- If `pause_all` drops while in IDLE (a spurious restart), `cmd_ready` goes low and no state change occurs.
- Reset asserted mid-render: all registers take their reset values immediately (asynchronous) and the state becomes RENDER.
- All outputs except `cmd_ready` are registered.

## Test plan
- Reset release with `pause_all` held 0 for 100 cycles, then 1 -> outputs hold the default values; `busy` drops; `render_cycles` = 100 ±1; `cmd_ready` = 1.
- cmd 5 accepted from scale = 65536 -> scale_wire = 49152; single coincident `valid`/`update` pulse 2 cycles after accept. Model ack at +1, `pause_all` high 50 cycles later -> `render_cycles` = 50.
- Repeat cmd 5 forty times -> scale never drops below 64. Repeat cmd 6 -> scale saturates at 131071 and never goes negative.
- `step_sel` = 3, cmd 7 repeated from c_real = −26214 -> values −25190, −24166, …; saturation at 131071 with no wrap.
- `pause_all` stuck at 1 after an update -> `ack_error` = 1 after 15 cycles; state returns to IDLE; the next command is still accepted.
- cmd 13 accepted -> no `update` pulse and parameters unchanged. Reset pulsed during RENDER -> asynchronous return to defaults, `ack_error` = 0.
